// File: rtl/herm_pkg.sv
// Shared constants, FSM state type and skid-buffer payload for the
// Hermitian-remover readout sequencer.
package herm_pkg;

   localparam int unsigned ACTIVE_SUBCARR = 28;
   localparam int unsigned SYMBOL_NUM     = 8;
   localparam int unsigned FFT_POINT      = 64;
   localparam int unsigned DATA_W         = 16;
   localparam int unsigned PTR_W          = 8;
   localparam int unsigned FULL_TIMEOUT   = 1024;

   localparam int unsigned IN_WORDS  = FFT_POINT * SYMBOL_NUM;
   localparam int unsigned OUT_WORDS = ACTIVE_SUBCARR * SYMBOL_NUM;

   localparam int unsigned IN_CNT_W  = $clog2(IN_WORDS + 1);
   localparam int unsigned OUT_CNT_W = $clog2(OUT_WORDS + 1);
   localparam int unsigned TMR_W     = $clog2(FULL_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      WAIT_FULL,
      READ,
      DONE
   } state_e;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } skid_word_t;

endpackage

// File: rtl/herm_skid_fifo.sv
// Two-entry shift-style skid FIFO; the head always sits in slot 0 so the
// stream outputs come straight from a flop.
module herm_skid_fifo
   import herm_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  skid_word_t din,
   output skid_word_t head,
   output logic       full,
   output logic       empty,
   output logic [1:0] free_slots
);

   logic [1:0] cnt_q, cnt_d;
   skid_word_t mem0_q, mem0_d;
   skid_word_t mem1_q, mem1_d;
   logic       do_push;
   logic       do_pop;

   always_comb begin
      do_pop  = pop && (cnt_q != 2'd0);
      do_push = push && ((cnt_q != 2'd2) || do_pop);
      cnt_d   = cnt_q;
      mem0_d  = mem0_q;
      mem1_d  = mem1_q;
      case ({do_push, do_pop})
         2'b10: begin
            if (cnt_q == 2'd0) mem0_d = din;
            else               mem1_d = din;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            mem0_d = mem1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               mem0_d = din;
            end else begin
               mem0_d = mem1_q;
               mem1_d = din;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 2'd0;
         mem0_q <= '0;
         mem1_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         mem0_q <= mem0_d;
         mem1_q <= mem1_d;
      end
   end

   assign head       = mem0_q;
   assign full       = (cnt_q == 2'd2);
   assign empty      = (cnt_q == 2'd0);
   assign free_slots = 2'd2 - cnt_q;

endmodule

// File: rtl/herm_readout_ctrl.sv
// Burst sequencer: gates FFT words into the Hermitian remover, waits for it to
// fill, reads out the active subcarriers into a valid/ready stream, re-arms it.
module herm_readout_ctrl
   import herm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              fft_valid,
   input  logic [DATA_W-1:0] fft_data,
   output logic [DATA_W-1:0] rm_din,
   output logic              rm_wren,
   input  logic              rm_full,
   output logic [PTR_W-1:0]  rm_rd_ptr,
   input  logic [DATA_W-1:0] rm_dout,
   output logic              rm_tx_done,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              busy,
   output logic              err_timeout
);

   state_e                 state_q, state_d;
   logic [IN_CNT_W-1:0]    in_cnt_q, in_cnt_d;
   logic [OUT_CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
   logic [OUT_CNT_W-1:0]   out_cnt_q, out_cnt_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;
   logic                   inflight_q, inflight_d;
   logic                   inflight_last_q, inflight_last_d;
   logic                   rearm_q, rearm_d;
   logic                   pend_q, pend_d;
   logic                   err_q, err_d;
   logic                   txd_q, txd_d;
   logic                   busy_q, busy_d;

   skid_word_t             fifo_din, fifo_head;
   logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [1:0]             fifo_free;
   logic [2:0]             free_eff;
   logic                   issue;

   assign fifo_din  = {inflight_last_q, rm_dout};
   assign fifo_pop  = !fifo_empty && m_tready;
   assign fifo_push = inflight_q && (!fifo_full || fifo_pop);

   herm_skid_fifo u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (fifo_push),
      .pop        (fifo_pop),
      .din        (fifo_din),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .free_slots (fifo_free)
   );

   // Next-state, counters and pulse generation
   always_comb begin
      state_d         = state_q;
      in_cnt_d        = in_cnt_q;
      rd_cnt_d        = rd_cnt_q;
      out_cnt_d       = out_cnt_q;
      tmr_d           = tmr_q;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      rearm_d         = rearm_q;
      pend_d          = 1'b0;
      err_d           = err_q;
      txd_d           = 1'b0;
      // a fetch may issue only if the slot it will land in is guaranteed free
      free_eff        = 3'(fifo_free) + 3'(fifo_pop);
      issue           = 1'b0;

      case (state_q)
         IDLE: begin
            in_cnt_d  = '0;
            rd_cnt_d  = '0;
            out_cnt_d = '0;
            tmr_d     = '0;
            if (pend_q) begin
               state_d = FILL;
            end else if (start) begin
               err_d = 1'b0;
               // remover contents survive our reset: flush it once before filling
               if (rearm_q) begin
                  txd_d   = 1'b1;
                  rearm_d = 1'b0;
                  pend_d  = 1'b1;
               end else begin
                  state_d = FILL;
               end
            end
         end
         FILL: begin
            if (fft_valid) begin
               in_cnt_d = in_cnt_q + IN_CNT_W'(1);
               if (in_cnt_q == IN_CNT_W'(IN_WORDS - 1)) state_d = WAIT_FULL;
            end
         end
         WAIT_FULL: begin
            if (rm_full) begin
               state_d = READ;
            end else if (tmr_q == TMR_W'(FULL_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         READ: begin
            issue = (rd_cnt_q < OUT_CNT_W'(OUT_WORDS)) && (free_eff > 3'(inflight_q));
            inflight_d      = issue;
            inflight_last_d = issue && (rd_cnt_q == OUT_CNT_W'(OUT_WORDS - 1));
            rd_cnt_d        = rd_cnt_q + OUT_CNT_W'(issue);
            if (fifo_pop) begin
               out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
               if (out_cnt_q == OUT_CNT_W'(OUT_WORDS - 1)) state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      txd_d  = txd_d || (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         in_cnt_q        <= '0;
         rd_cnt_q        <= '0;
         out_cnt_q       <= '0;
         tmr_q           <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         rearm_q         <= 1'b1;
         pend_q          <= 1'b0;
         err_q           <= 1'b0;
         txd_q           <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         in_cnt_q        <= in_cnt_d;
         rd_cnt_q        <= rd_cnt_d;
         out_cnt_q       <= out_cnt_d;
         tmr_q           <= tmr_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         rearm_q         <= rearm_d;
         pend_q          <= pend_d;
         err_q           <= err_d;
         txd_q           <= txd_d;
         busy_q          <= busy_d;
      end
   end

   assign rm_wren     = (state_q == FILL) && fft_valid;
   assign rm_din      = (state_q == FILL) ? fft_data : '0;
   assign rm_rd_ptr   = PTR_W'(rd_cnt_q);
   assign rm_tx_done  = txd_q;
   assign m_tvalid    = !fifo_empty;
   assign m_tdata     = fifo_head.data;
   assign m_tlast     = fifo_head.last && !fifo_empty;
   assign busy        = busy_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_herm_readout_ctrl.sv
// Randomized bench for herm_readout_ctrl with a behavioural remover stub and
// an arithmetic expectation of the kept-subcarrier stream.
module tb_herm_readout_ctrl;
   import herm_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              fft_valid = 1'b0;
   logic [DATA_W-1:0] fft_data = '0;
   logic [DATA_W-1:0] rm_din;
   logic              rm_wren;
   logic              rm_full = 1'b0;
   logic [PTR_W-1:0]  rm_rd_ptr;
   logic [DATA_W-1:0] rm_dout = '0;
   logic              rm_tx_done;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready = 1'b1;
   logic              m_tlast;
   logic              busy;
   logic              err_timeout;

   int n_checks = 0;
   int n_err    = 0;

   herm_readout_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .fft_valid   (fft_valid),
      .fft_data    (fft_data),
      .rm_din      (rm_din),
      .rm_wren     (rm_wren),
      .rm_full     (rm_full),
      .rm_rd_ptr   (rm_rd_ptr),
      .rm_dout     (rm_dout),
      .rm_tx_done  (rm_tx_done),
      .m_tdata     (m_tdata),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .m_tlast     (m_tlast),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Remover stub: stores written words, flags full, returns kept subcarriers; not reset by rst_n
   logic [DATA_W-1:0] wmem [IN_WORDS];
   int  wcnt    = 0;
   bit  full_en = 1'b1;

   function automatic logic [DATA_W-1:0] kept_word(input logic [PTR_W-1:0] p);
      int unsigned k;
      k = int'(p);
      if (k >= OUT_WORDS) return '0;
      return wmem[FFT_POINT * (k / ACTIVE_SUBCARR) + 1 + (k % ACTIVE_SUBCARR)];
   endfunction

   always @(posedge clk) begin
      if (rm_tx_done) begin
         wcnt    <= 0;
         rm_full <= 1'b0;
      end else begin
         if (rm_wren && wcnt < int'(IN_WORDS)) begin
            wmem[wcnt] <= rm_din;
            wcnt       <= wcnt + 1;
         end
         rm_full <= full_en && (wcnt == int'(IN_WORDS));
      end
      rm_dout <= kept_word(rm_rd_ptr);
   end

   // Stream monitor
   logic [DATA_W-1:0] hs_data [$];
   bit                hs_last [$];
   bit                tv_seen = 1'b0;
   int                txd_high = 0;
   bit                stall_prev = 1'b0;
   logic [DATA_W-1:0] stall_data = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (m_tvalid) tv_seen = 1'b1;
         if (rm_tx_done) txd_high++;
         if (stall_prev) begin
            check("hold_valid", m_tvalid, 1'b1);
            check("hold_data", m_tdata, stall_data);
         end
         stall_prev = m_tvalid && !m_tready;
         stall_data = m_tdata;
         if (m_tvalid && m_tready) begin
            hs_data.push_back(m_tdata);
            hs_last.push_back(m_tlast);
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   int rearm_exp = 1;

   // mode: 0 ready=1, 1 toggle, 2 one 50-cycle stall, 3 random
   task automatic run_burst(input bit rnd_data, input int mode, input bit to_path,
                            input bit extra, input bit rst_mid);
      logic [DATA_W-1:0] sent [IN_WORDS];
      logic [PTR_W-1:0]  ptr_at;
      int  exp_txd, n, stall_cnt, lasts;
      bit  stall_started, ext_done, rst_hit;
      for (int i = 0; i < int'(IN_WORDS); i++)
         sent[i] = rnd_data ? DATA_W'($urandom) : DATA_W'(i);
      hs_data.delete();
      hs_last.delete();
      tv_seen  = 1'b0;
      txd_high = 0;
      full_en  = !to_path;
      m_tready = 1'b1;
      exp_txd  = 1 + rearm_exp;
      ptr_at   = '0;

      if (extra) begin
         for (int k = 0; k < 3; k++) begin
            fft_valid = 1'b1;
            fft_data  = DATA_W'($urandom);
            #1;
            check("idle_wren", rm_wren, 1'b0);
            @(posedge clk); #1;
         end
         fft_valid = 1'b0;
      end

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      rearm_exp = 0;
      n = 0;
      while (!busy && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("busy_after_start", busy, 1'b1);
      check("err_cleared", err_timeout, 1'b0);

      for (int i = 0; i < int'(IN_WORDS); i++) begin
         while ($urandom_range(3) == 0) begin
            fft_valid = 1'b0;
            start     = 1'b0;
            @(posedge clk); #1;
         end
         fft_valid = 1'b1;
         fft_data  = sent[i];
         start     = extra && (i == 200);
         @(posedge clk); #1;
      end
      fft_valid = 1'b0;
      start     = 1'b0;

      if (to_path) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!rm_tx_done && n < 1200);
         check("timeout_latency", n, 1025);
         check("timeout_err", err_timeout, 1'b1);
         @(posedge clk); #1;
         check("timeout_idle", busy, 1'b0);
         repeat (5) @(posedge clk);
         #1;
         check("err_sticky", err_timeout, 1'b1);
         check("timeout_no_valid", tv_seen, 1'b0);
         check("timeout_txd", txd_high, exp_txd);
         full_en = 1'b1;
         return;
      end

      stall_started = 1'b0;
      stall_cnt     = 0;
      ext_done      = 1'b0;
      rst_hit       = 1'b0;
      for (n = 0; n < 4000; n++) begin
         @(posedge clk); #1;
         if (!busy) break;
         start = extra && !ext_done && (hs_data.size() >= 50);
         if (start) ext_done = 1'b1;
         if (rst_mid && hs_data.size() >= 100) begin
            rst_n = 1'b0;
            #1;
            check("rst_busy", busy, 1'b0);
            check("rst_tvalid", m_tvalid, 1'b0);
            check("rst_tdata", m_tdata, '0);
            check("rst_tlast", m_tlast, 1'b0);
            check("rst_ptr", rm_rd_ptr, '0);
            check("rst_wren", rm_wren, 1'b0);
            check("rst_txd", rm_tx_done, 1'b0);
            @(posedge clk); #1;
            rst_n     = 1'b1;
            rearm_exp = 1;
            rst_hit   = 1'b1;
            break;
         end
         case (mode)
            1: m_tready = !m_tready;
            2: begin
               if (!stall_started && hs_data.size() >= 60) begin
                  stall_started = 1'b1;
                  stall_cnt     = 50;
               end
               if (stall_cnt > 0) begin
                  m_tready = 1'b0;
                  stall_cnt--;
                  if (stall_cnt == 40) ptr_at = rm_rd_ptr;
                  if (stall_cnt == 1) begin
                     check("stall_ptr_frozen", rm_rd_ptr, ptr_at);
                     check("stall_ptr_ahead", rm_rd_ptr, hs_data.size() + 2);
                     check("stall_valid", m_tvalid, 1'b1);
                  end
               end else begin
                  m_tready = 1'b1;
               end
            end
            3: m_tready = ($urandom_range(3) != 0);
            default: m_tready = 1'b1;
         endcase
      end
      start = 1'b0;
      if (rst_hit) begin
         repeat (2) @(posedge clk);
         #1;
         check("post_rst_err", err_timeout, 1'b0);
         return;
      end

      check("burst_finished", busy, 1'b0);
      check("word_count", hs_data.size(), OUT_WORDS);
      for (int i = 0; i < hs_data.size() && i < int'(OUT_WORDS); i++)
         check($sformatf("word%0d", i), hs_data[i],
               sent[FFT_POINT * (i / ACTIVE_SUBCARR) + 1 + (i % ACTIVE_SUBCARR)]);
      lasts = 0;
      foreach (hs_last[i]) if (hs_last[i]) lasts++;
      check("tlast_count", lasts, 1);
      if (hs_last.size() == int'(OUT_WORDS)) check("tlast_pos", hs_last[OUT_WORDS-1], 1'b1);
      check("txd_pulses", txd_high, exp_txd);
      check("err_clear", err_timeout, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("init_busy", busy, 1'b0);
      check("init_tvalid", m_tvalid, 1'b0);
      check("init_ptr", rm_rd_ptr, '0);
      check("init_txd", rm_tx_done, 1'b0);
      check("init_err", err_timeout, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_burst(1'b0, 0, 1'b0, 1'b0, 1'b0);
      run_burst(1'b1, 1, 1'b0, 1'b0, 1'b0);
      run_burst(1'b1, 2, 1'b0, 1'b0, 1'b0);
      run_burst(1'b1, 0, 1'b1, 1'b0, 1'b0);
      run_burst(1'b1, 0, 1'b0, 1'b0, 1'b1);
      run_burst(1'b1, 3, 1'b0, 1'b0, 1'b0);
      run_burst(1'b1, 3, 1'b0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
